opti_out_buffer: RTL and testbench
==================================

Name: opti_out_buffer

Overview:
- Downstream capture stage for the 7-section IIR filter top; consumes its output stream (data_out, data_out_valid, addr, filter_done, stable_out).
- Stores one filtered block of up to DEPTH samples in internal RAM.
- Records the sample index at which the filter first reported stable output, and checks the addr sequence.
- After the block completes, exposes a registered read port so a host or bench can drain results.

Parameters:
DW, 16, sample width (two's complement)
AW, 11, address width; DEPTH = 2**AW = 2048

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle pulse; arms a new capture
din  input  DW  filter output sample (data_out)
din_valid  input  1  filter output valid (data_out_valid)
din_addr  input  AW  filter sample index (addr)
filter_done  input  1  filter block-complete pulse/level
stable_in  input  1  filter stable_out
busy  output  1  high in CAPTURE
done  output  1  high in DONE
count  output  AW+1  samples captured, 0..DEPTH
settle_idx  output  AW  write index of first valid sample with stable_in=1
settled  output  1  settle_idx is valid
addr_err  output  1  sticky: din_addr != wr_ptr on some valid sample
rd_en  input  1  read request, honoured only in DONE
rd_addr  input  AW  read index
rd_data  output  DW  read data, 1-cycle latency
rd_valid  output  1  rd_data valid, 1 cycle after accepted rd_en
peak  output  DW  max |sample| (OPTI_BUF_PEAK_EN only; else 0)

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; busy=0, done=0, count=0, settle_idx=0, settled=0, addr_err=0, rd_data=0, rd_valid=0, peak=0, wr_ptr=0. RAM contents are not cleared. Reset has priority over every other input, including mid-CAPTURE; it aborts the capture.
- State machine: IDLE, CAPTURE, DONE.
  - IDLE -> CAPTURE on start. Clears count, wr_ptr, settled, settle_idx, addr_err and peak.
  - CAPTURE: each cycle with din_valid=1:
    - RAM[wr_ptr] <= din; wr_ptr++; count++.
    - If din_addr != wr_ptr, set addr_err.
    - If stable_in=1 and settled=0, set settle_idx <= wr_ptr and settled <= 1.
  - CAPTURE -> DONE when filter_done=1 or when the write brings count to DEPTH.
    - If filter_done and din_valid occur in the same cycle, that sample is still written, then the state moves to DONE.
    - Once count=DEPTH, wr_ptr stops at DEPTH-1 and further valid samples are dropped (no wrap, no overwrite).
  - DONE -> CAPTURE on start (re-arm, same clears as IDLE). start in CAPTURE is ignored.
  - din_valid in IDLE or DONE is ignored.
- busy=(state==CAPTURE), done=(state==DONE), both registered.
- Read port:
  - rd_en in DONE: rd_data <= RAM[rd_addr], rd_valid=1 on the next cycle.
  - rd_en outside DONE: rd_valid=0 and rd_data holds its previous value.
  - rd_addr >= count is legal and returns stale RAM contents.
- Latency: write to visible count = 1 cycle. filter_done to done=1 is 1 cycle.
- RAM: single write port, single synchronous read port. Read and write never coincide (write only in CAPTURE, read only in DONE).

Optional Feature:
OPTI_BUF_PEAK_EN
- Defined: on each written sample, a = |din|, with -2**(DW-1) saturating to 2**(DW-1)-1. peak <= max(peak, a). peak updates 1 cycle after the write, is cleared on start, and holds in DONE.
- Undefined: no abs/compare logic; peak tied to 0.

Test Plan:
- Reset, then start, then 2048 consecutive valid samples din=i, din_addr=i -> count=2048, done=1 one cycle after last write, addr_err=0. Reading addr 0x7FF returns 0x07FF with rd_valid one cycle later.
- Capture of 100 samples, then filter_done coincident with the 101st valid -> 101st written, count=101, done=1; later din_valid ignored, count stays 101.
- stable_in rises at sample 37 and toggles afterwards -> settle_idx=37, settled=1, unchanged by later toggles.
- din_addr skips from 5 to 7 -> addr_err=1, sticky through DONE. Next start clears it to 0.
- rst=1 mid-capture at count=500 -> next cycle busy=0, done=0, count=0. rd_en then gives rd_valid=0.
- With OPTI_BUF_PEAK_EN, samples 0x1000, 0x8000, 0xF000 -> peak=0x7FFF. Without the macro, peak=0.

Source files
------------

// File: rtl/opti_out_buffer.sv
// Capture buffer for one filtered IIR block: stores samples, tracks settle point and addr ordering,
// then serves a registered read port. Optional peak-|sample| tracking under OPTI_BUF_PEAK_EN.
module opti_out_buffer #(
    parameter int DW = 16,
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    input  logic [AW-1:0] din_addr,
    input  logic          filter_done,
    input  logic          stable_in,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   count,
    output logic [AW-1:0] settle_idx,
    output logic          settled,
    output logic          addr_err,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic [DW-1:0] peak
);
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_LAST = (AW + 1)'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_MAX  = '1;

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_e;

    state_e        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] settle_idx_q, settle_idx_d;
    logic          settled_q, settled_d;
    logic          addr_err_q, addr_err_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          wr_en;
    logic          arm;

    logic [DW-1:0] mem [DEPTH];

`ifdef OPTI_BUF_PEAK_EN
    logic [DW-1:0] peak_q, peak_d;
    logic [DW-1:0] din_abs;
    // The most negative code has no positive twin, so it saturates.
    always_comb begin
        din_abs = din;
        if (din[DW-1])
            din_abs = (din == {1'b1, {(DW-1){1'b0}}}) ? {1'b0, {(DW-1){1'b1}}} : -din;
    end
`endif

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        settle_idx_d = settle_idx_q;
        settled_d    = settled_q;
        addr_err_d   = addr_err_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        wr_en        = 1'b0;
        arm          = start && (state_q != CAPTURE);
`ifdef OPTI_BUF_PEAK_EN
        peak_d       = peak_q;
`endif
        case (state_q)
            CAPTURE: begin
                if (din_valid && (count_q != CNT_FULL)) begin
                    wr_en    = 1'b1;
                    count_d  = count_q + 1'b1;
                    // Pointer parks on the last slot once full: no wrap, no overwrite.
                    wr_ptr_d = (wr_ptr_q == PTR_MAX) ? wr_ptr_q : wr_ptr_q + 1'b1;
                    if (din_addr != wr_ptr_q)
                        addr_err_d = 1'b1;
                    if (stable_in && !settled_q) begin
                        settle_idx_d = wr_ptr_q;
                        settled_d    = 1'b1;
                    end
`ifdef OPTI_BUF_PEAK_EN
                    if (din_abs > peak_q)
                        peak_d = din_abs;
`endif
                end
                if (filter_done || (wr_en && (count_q == CNT_LAST)) || (count_q == CNT_FULL))
                    state_d = DONE;
            end
            DONE: begin
                if (rd_en) begin
                    rd_data_d  = mem[rd_addr];
                    rd_valid_d = 1'b1;
                end
            end
            default: ;
        endcase
        if (arm) begin
            state_d      = CAPTURE;
            count_d      = '0;
            wr_ptr_d     = '0;
            settle_idx_d = '0;
            settled_d    = 1'b0;
            addr_err_d   = 1'b0;
            rd_valid_d   = 1'b0;
            rd_data_d    = rd_data_q;
`ifdef OPTI_BUF_PEAK_EN
            peak_d       = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            settle_idx_q <= '0;
            settled_q    <= 1'b0;
            addr_err_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
`ifdef OPTI_BUF_PEAK_EN
            peak_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            settle_idx_q <= settle_idx_d;
            settled_q    <= settled_d;
            addr_err_q   <= addr_err_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
`ifdef OPTI_BUF_PEAK_EN
            peak_q       <= peak_d;
`endif
        end
    end

    // RAM contents survive reset; only the write port lives here.
    always_ff @(posedge clk) begin
        if (wr_en && !rst)
            mem[wr_ptr_q] <= din;
    end

    assign busy       = (state_q == CAPTURE);
    assign done       = (state_q == DONE);
    assign count      = count_q;
    assign settle_idx = settle_idx_q;
    assign settled    = settled_q;
    assign addr_err   = addr_err_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
`ifdef OPTI_BUF_PEAK_EN
    assign peak       = peak_q;
`else
    assign peak       = '0;
`endif

endmodule

// File: tb/tb_opti_out_buffer.sv
// Scoreboard bench for opti_out_buffer: reference RAM model feeds an expected-read queue.
module tb_opti_out_buffer;
    localparam int DW = 16;
    localparam int AW = 11;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic [AW-1:0] din_addr = '0;
    logic          filter_done = 1'b0;
    logic          stable_in = 1'b0;
    logic          busy, done, settled, addr_err, rd_valid;
    logic [AW:0]   count;
    logic [AW-1:0] settle_idx;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data, peak;

    int total = 0;
    int bad = 0;
    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] sb_q [$];

    opti_out_buffer #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
        .din_addr(din_addr), .filter_done(filter_done), .stable_in(stable_in),
        .busy(busy), .done(done), .count(count), .settle_idx(settle_idx),
        .settled(settled), .addr_err(addr_err), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .peak(peak)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One valid sample; the model RAM tracks what an in-range write should store.
    task automatic wr(input logic [DW-1:0] d, input logic [AW-1:0] a, input logic st, input logic fd);
        din = d; din_addr = a; stable_in = st; filter_done = fd; din_valid = 1'b1;
        if (busy && count < (AW+1)'(DEPTH)) mem_m[count[AW-1:0]] = d;
        step();
        din_valid = 1'b0; filter_done = 1'b0; stable_in = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        rd_en = 1'b1; rd_addr = a;
        if (done) sb_q.push_back(mem_m[a]);
        step();
        rd_en = 1'b0;
    endtask

    task automatic arm();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rd_valid) begin
            if (sb_q.size() == 0) chk("rd_unexpected", 32'(rd_valid), 32'd0);
            else chk("rd_data", 32'(rd_data), 32'(sb_q.pop_front()));
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] pk_exp;
        step(); step();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_settled", 32'(settled), 0);
        chk("rst_addr_err", 32'(addr_err), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_peak", 32'(peak), 0);

        // Full block of 2048 samples
        arm();
        chk("arm_busy", 32'(busy), 1);
        for (int i = 0; i < DEPTH; i++) begin
            wr(DW'(i), AW'(i), 1'b0, 1'b0);
            if (i == 10) chk("cnt_lat", 32'(count), 11);
            if (i == DEPTH - 2) chk("busy_before_last", 32'(done), 0);
        end
        chk("full_count", 32'(count), DEPTH);
        chk("full_done", 32'(done), 1);
        chk("full_busy", 32'(busy), 0);
        chk("full_addr_err", 32'(addr_err), 0);
`ifdef OPTI_BUF_PEAK_EN
        pk_exp = 16'h07FF;
`else
        pk_exp = 16'h0000;
`endif
        chk("full_peak", 32'(peak), 32'(pk_exp));
        wr(16'hBEEF, 11'd0, 1'b0, 1'b0);
        chk("done_ignore_valid", 32'(count), DEPTH);
        rd(11'h7FF);
        chk("rd_7ff_valid", 32'(rd_valid), 1);
        chk("rd_7ff_data", 32'(rd_data), 32'h07FF);
        rd(11'h000);
        rd(11'h123);
        step();
        chk("rd_valid_drop", 32'(rd_valid), 0);

        // 100 samples + filter_done on the 101st; settle at 37
        arm();
        chk("rearm_count", 32'(count), 0);
        chk("rearm_peak", 32'(peak), 0);
        for (int i = 0; i < 100; i++) begin
            wr(DW'($urandom_range(0, 16'h3FFF)), AW'(i), (i >= 37) ? 1'(i % 2) : 1'b0, 1'b0);
            if (i == 36) chk("not_settled_yet", 32'(settled), 0);
        end
        chk("mid_busy", 32'(busy), 1);
        wr(16'h1234, 11'd100, 1'b1, 1'b1);
        chk("fd_count", 32'(count), 101);
        chk("fd_done", 32'(done), 1);
        chk("settle_idx", 32'(settle_idx), 37);
        chk("settled", 32'(settled), 1);
        wr(16'h5555, 11'd101, 1'b1, 1'b0);
        wr(16'h6666, 11'd102, 1'b0, 1'b0);
        chk("fd_count_hold", 32'(count), 101);
        chk("settle_idx_hold", 32'(settle_idx), 37);
        rd(11'd100);
        rd(11'd37);
        rd(11'd0);
        rd(11'd500);

        // addr skip 5 -> 7
        arm();
        chk("rearm_settled", 32'(settled), 0);
        for (int i = 0; i < 6; i++) wr(DW'(i), AW'(i), 1'b0, 1'b0);
        chk("no_err_yet", 32'(addr_err), 0);
        wr(16'd6, 11'd7, 1'b0, 1'b0);
        chk("addr_err_set", 32'(addr_err), 1);
        wr(16'd7, 11'd7, 1'b0, 1'b1);
        chk("addr_err_done", 32'(done), 1);
        chk("addr_err_sticky", 32'(addr_err), 1);
        arm();
        chk("addr_err_clear", 32'(addr_err), 0);

        // Peak: 0x1000, 0x8000, 0xF000
        wr(16'h1000, 11'd0, 1'b0, 1'b0);
        wr(16'h8000, 11'd1, 1'b0, 1'b0);
        wr(16'hF000, 11'd2, 1'b0, 1'b1);
`ifdef OPTI_BUF_PEAK_EN
        pk_exp = 16'h7FFF;
`else
        pk_exp = 16'h0000;
`endif
        chk("peak_sat", 32'(peak), 32'(pk_exp));
        rd(11'd1);

        // Reset mid-capture at count=500
        arm();
        for (int i = 0; i < 500; i++) wr(DW'(i * 3), AW'(i), 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count), 500);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_count", 32'(count), 0);
        rd(11'd3);
        chk("abort_rd_valid", 32'(rd_valid), 0);
        step(); step();

        chk("sb_drain", 32'(sb_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
